// File: rtl/uartp_pkg.sv
// Shared types and default constants for the UART boot loader slice.
package uartp_pkg;

  localparam int DEFAULT_WORD_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_CLK_DIV    = 434;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    DATA,
    DONE
  } loader_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_mem_loader_rx.sv
// UART 8N1-style receiver: synchroniser, mid-bit sampling timer and shift register.
module uart_rx
  import uartp_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  byte_valid,
  output logic [WORD_WIDTH-1:0] byte_data,
  output logic                  frame_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(WORD_WIDTH - 1);

  logic                  rx_meta;
  logic                  rx_sync;
  logic                  rx_prev;
  rx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         idx;
  logic [WORD_WIDTH-1:0] shift_reg;

  // rx_prev lets the idle state look for a true high-to-low edge rather than a low level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift_reg  <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            shift_reg <= {rx_sync, shift_reg[WORD_WIDTH-1:1]};
            if (idx == IDX_LAST) state <= RX_STOP;
            else                 idx   <= idx + BW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift_reg;
              state      <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Serial boot loader: a length word followed by that many payload words, written to memory.
module uart_mem_loader
  import uartp_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  load_en,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  frame_err
);

  logic                  rx_valid;
  logic [WORD_WIDTH-1:0] rx_byte;
  logic                  rx_frame_err;
  loader_state_t         state;
  logic                  armed;
  logic [WORD_WIDTH-1:0] remaining;

  uart_rx #(
    .WORD_WIDTH(WORD_WIDTH),
    .CLK_DIV   (CLK_DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (rx_frame_err)
  );

  // The address advances on the cycle after each strobe, so a write always sees the current slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      remaining <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_write <= 1'b0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      load_done <= 1'b0;
      if (mem_write) mem_addr <= mem_addr + ADDR_WIDTH'(1);
      if (!load_en)  armed    <= 1'b1;
      case (state)
        IDLE: begin
          cpu_hold <= 1'b0;
          if (load_en && armed) begin
            state     <= LEN;
            cpu_hold  <= 1'b1;
            frame_err <= 1'b0;
            armed     <= 1'b0;
          end
        end
        LEN: begin
          if (!load_en) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end else begin
            if (rx_frame_err) frame_err <= 1'b1;
            if (rx_valid) begin
              remaining <= rx_byte;
              mem_addr  <= '0;
              if (rx_byte == '0) begin
                state     <= DONE;
                load_done <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (!load_en) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end else begin
            if (rx_frame_err) frame_err <= 1'b1;
            if (rx_valid) begin
              mem_write <= 1'b1;
              mem_data  <= rx_byte;
              remaining <= remaining - WORD_WIDTH'(1);
              if (remaining == WORD_WIDTH'(1)) begin
                state     <= DONE;
                load_done <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          cpu_hold <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader against a word-list model of the load protocol.
module tb_uart_mem_loader;

  localparam int WW   = 8;
  localparam int AW   = 3;
  localparam int CDIV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          load_en = 1'b0;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_data;
  logic          cpu_hold;
  logic          load_done;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;
  int obs_base;
  logic [AW+WW-1:0] obs_q[$];
  logic [WW-1:0]    words[$];

  uart_mem_loader #(
    .WORD_WIDTH(WW),
    .ADDR_WIDTH(AW),
    .CLK_DIV   (CDIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .load_en  (load_en),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Record every write strobe and done pulse seen on the memory side
  always @(negedge clk) begin
    if (mem_write) obs_q.push_back({mem_addr, mem_data});
    if (load_done) done_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [WW-1:0] b, input logic stop);
    rx = 1'b0;
    idle(CDIV);
    for (int i = 0; i < WW; i++) begin
      rx = b[i];
      idle(CDIV);
    end
    rx = stop;
    idle(CDIV);
    rx = 1'b1;
  endtask

  task automatic send_words();
    foreach (words[i]) begin
      send_frame(words[i], 1'b1);
      idle(3 * CDIV);
    end
  endtask

  task automatic start_load();
    load_en = 1'b0;
    idle(2);
    obs_base  = obs_q.size();
    done_base = done_cnt;
    load_en = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    load_en = 1'b0;
    idle(3);
    checks++;
    if ({mem_write, mem_addr, mem_data, cpu_hold, load_done, frame_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got w=%b a=%h d=%h h=%b dn=%b fe=%b, want all 0",
               mem_write, mem_addr, mem_data, cpu_hold, load_done, frame_err);
    end
    rst = 1'b0;
    idle(3);
    checks++;
    if ({mem_write, cpu_hold, load_done, frame_err} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got w=%b h=%b dn=%b fe=%b, want 0",
               mem_write, cpu_hold, load_done, frame_err);
    end
  endtask

  task automatic test_basic();
    start_load();
    checks++;
    if (cpu_hold !== 1'b1 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_hold: got hold=%b fe=%b, want 1 0", cpu_hold, frame_err);
    end
    words = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
    send_words();
    idle(4);
    checks++;
    if (obs_q.size() - obs_base !== 3) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d writes, want 3", obs_q.size() - obs_base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[obs_base + i] !== {AW'(i), words[i + 1]}) begin
          errors++;
          $display("[TB] FAIL basic_write%0d: got %h, want %h", i, obs_q[obs_base + i],
                   {AW'(i), words[i + 1]});
        end
      end
    end
    checks++;
    if (done_cnt - done_base !== 1 || cpu_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done: got done=%0d hold=%b, want 1 0", done_cnt - done_base, cpu_hold);
    end
    load_en = 1'b0;
  endtask

  task automatic test_zero_length();
    bit seen = 0;
    start_load();
    send_frame(8'h00, 1'b1);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (load_done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL zero_done_timeout: got no load_done in 40 cycles, want pulse");
    end else begin
      checks++;
      if (cpu_hold !== 1'b1) begin
        errors++;
        $display("[TB] FAIL zero_hold_at_done: got %b, want 1", cpu_hold);
      end
      @(negedge clk);
      checks++;
      if (cpu_hold !== 1'b0 || load_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL zero_after_done: got hold=%b done=%b, want 0 0", cpu_hold, load_done);
      end
    end
    idle(4);
    checks++;
    if (obs_q.size() !== obs_base || done_cnt - done_base !== 1) begin
      errors++;
      $display("[TB] FAIL zero_writes: got %0d writes %0d dones, want 0 1",
               obs_q.size() - obs_base, done_cnt - done_base);
    end
    load_en = 1'b0;
  endtask

  task automatic run_list_load(input string name);
    start_load();
    send_words();
    idle(4);
    checks++;
    if (obs_q.size() - obs_base !== int'(words[0])) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d writes, want %0d", name, obs_q.size() - obs_base, words[0]);
    end else begin
      for (int i = 0; i < int'(words[0]); i++) begin
        checks++;
        if (obs_q[obs_base + i] !== {AW'(i % (1 << AW)), words[i + 1]}) begin
          errors++;
          $display("[TB] FAIL %s_write%0d: got %h, want %h", name, i, obs_q[obs_base + i],
                   {AW'(i % (1 << AW)), words[i + 1]});
        end
      end
    end
    checks++;
    if (done_cnt - done_base !== 1 || cpu_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done: got done=%0d hold=%b, want 1 0", name, done_cnt - done_base, cpu_hold);
    end
    load_en = 1'b0;
  endtask

  task automatic test_wrap();
    words = {};
    words.push_back(8'h0A);
    for (int i = 0; i < 10; i++) words.push_back(WW'(8'h10 + i));
    run_list_load("wrap");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      words = {};
      words.push_back(WW'($urandom_range(1, 12)));
      for (int i = 0; i < int'(words[0]); i++) words.push_back(WW'($urandom));
      run_list_load("random");
    end
  endtask

  task automatic test_frame_error();
    start_load();
    send_frame(8'h02, 1'b1);
    idle(3 * CDIV);
    send_frame(8'h55, 1'b0);
    idle(3 * CDIV);
    words = '{8'h66, 8'h77};
    send_words();
    idle(4);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ferr_sticky: got %b, want 1", frame_err);
    end
    checks++;
    if (obs_q.size() - obs_base !== 2 || obs_q[obs_base] !== {3'd0, 8'h66} ||
        obs_q[obs_base + 1] !== {3'd1, 8'h77}) begin
      errors++;
      $display("[TB] FAIL ferr_writes: got %0d writes first=%h, want 2 starting %h",
               obs_q.size() - obs_base, obs_q[obs_base], {3'd0, 8'h66});
    end
    checks++;
    if (done_cnt - done_base !== 1) begin
      errors++;
      $display("[TB] FAIL ferr_done: got %0d, want 1", done_cnt - done_base);
    end
    load_en = 1'b0;
    start_load();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ferr_cleared_on_load: got %b, want 0", frame_err);
    end
    send_frame(8'h00, 1'b1);
    idle(3 * CDIV);
    load_en = 1'b0;
  endtask

  task automatic test_glitch();
    start_load();
    rx = 1'b0;
    idle(CDIV / 2 - 1);
    rx = 1'b1;
    idle(12 * CDIV);
    checks++;
    if (cpu_hold !== 1'b1 || frame_err !== 1'b0 || obs_q.size() !== obs_base ||
        done_cnt !== done_base) begin
      errors++;
      $display("[TB] FAIL glitch: got hold=%b fe=%b writes=%0d dones=%0d, want 1 0 0 0",
               cpu_hold, frame_err, obs_q.size() - obs_base, done_cnt - done_base);
    end
    send_frame(8'h00, 1'b1);
    idle(3 * CDIV);
    load_en = 1'b0;
  endtask

  task automatic test_abort();
    start_load();
    words = '{8'h03, 8'hAA};
    send_words();
    load_en = 1'b0;
    idle(2);
    checks++;
    if (cpu_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_hold: got %b, want 0", cpu_hold);
    end
    words = '{8'hBB, 8'hCC};
    send_words();
    idle(4);
    checks++;
    if (obs_q.size() - obs_base !== 1 || obs_q[obs_base] !== {3'd0, 8'hAA} ||
        done_cnt !== done_base) begin
      errors++;
      $display("[TB] FAIL abort_writes: got %0d writes %0d dones, want 1 write AA@0 and 0 dones",
               obs_q.size() - obs_base, done_cnt - done_base);
    end
  endtask

  task automatic test_no_restart();
    start_load();
    send_frame(8'h00, 1'b1);
    idle(6 * CDIV);
    words = '{8'h01, 8'h42};
    send_words();
    idle(4);
    checks++;
    if (cpu_hold !== 1'b0 || obs_q.size() !== obs_base || done_cnt - done_base !== 1) begin
      errors++;
      $display("[TB] FAIL no_restart: got hold=%b writes=%0d dones=%0d, want 0 0 1",
               cpu_hold, obs_q.size() - obs_base, done_cnt - done_base);
    end
    load_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    start_load();
    words = '{8'h02, 8'h5A};
    send_words();
    rx = 1'b0;
    idle(3 * CDIV);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({mem_write, mem_addr, mem_data, cpu_hold, load_done, frame_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_frame: got w=%b a=%h d=%h h=%b dn=%b fe=%b, want all 0",
               mem_write, mem_addr, mem_data, cpu_hold, load_done, frame_err);
    end
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(12 * CDIV);
    checks++;
    if (cpu_hold !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_recovery: got hold=%b w=%b, want 0 0", cpu_hold, mem_write);
    end
    load_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_wrap();
    test_frame_error();
    test_glitch();
    test_random();
    test_abort();
    test_no_restart();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
